// File: rtl/derotate_z_seq.sv
// Iterative inverse of the fixed-angle z-rotation: undoes up to 2^STEP_W-1 shift-add
// steps, one per clock, with valid/ready handshakes and per-step saturation.
module derotate_z_seq #(
  parameter int WIDTH  = 10,
  parameter int STEP_W = 4,
  parameter int GUARD  = 2
) (
  input  logic              clk_100MHz,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  x_pt,
  input  logic [WIDTH-1:0]  y_pt,
  input  logic [STEP_W-1:0] steps,
  input  logic              dir,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  rotated_x,
  output logic [WIDTH-1:0]  rotated_y,
  output logic              busy
);

  localparam int IW = WIDTH + GUARD;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ROTATE = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  localparam logic signed [IW-1:0] C_MAX = {{(GUARD+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [IW-1:0] C_MIN = {{(GUARD+1){1'b1}}, {(WIDTH-1){1'b0}}};
  localparam logic [STEP_W-1:0]    C_ONE = {{(STEP_W-1){1'b0}}, 1'b1};
  localparam logic [STEP_W-1:0]    C_ZERO = {STEP_W{1'b0}};

  function automatic logic signed [IW-1:0] sat(input logic signed [IW-1:0] v);
    logic signed [IW-1:0] res;
    if (v > C_MAX) begin
      res = C_MAX;
    end else if (v < C_MIN) begin
      res = C_MIN;
    end else begin
      res = v;
    end
    return res;
  endfunction

  logic [1:0]              r_state;
  logic signed [IW-1:0]    r_x;
  logic signed [IW-1:0]    r_y;
  logic                    r_dir;
  logic [STEP_W-1:0]       r_cnt;
  logic [WIDTH-1:0]        r_out_x;
  logic [WIDTH-1:0]        r_out_y;
  logic                    r_in_ready;
  logic                    r_out_valid;
  logic                    r_busy;

  logic                    w_accept;
  logic signed [IW-1:0]    w_x_in;
  logic signed [IW-1:0]    w_y_in;
  logic signed [IW-1:0]    w_x_next;
  logic signed [IW-1:0]    w_y_next;
  logic signed [IW-1:0]    w_x_sat;
  logic signed [IW-1:0]    w_y_sat;

  // One inverse step from the pre-step x/y (simultaneous update), then clamp.
  always_comb begin
    w_accept = in_valid & r_in_ready;
    w_x_in   = {{GUARD{x_pt[WIDTH-1]}}, x_pt};
    w_y_in   = {{GUARD{y_pt[WIDTH-1]}}, y_pt};
    if (r_dir == 1'b0) begin
      w_x_next = r_x - (r_x >>> 3'd5) + (r_y >>> 3'd2) + (r_y >>> 3'd7);
      w_y_next = r_y - (r_y >>> 3'd5) - (r_x >>> 3'd2) - (r_x >>> 3'd7);
    end else begin
      w_x_next = r_x - (r_x >>> 3'd5) - (r_y >>> 3'd2) - (r_y >>> 3'd7);
      w_y_next = r_y - (r_y >>> 3'd5) + (r_x >>> 3'd2) + (r_x >>> 3'd7);
    end
    w_x_sat = sat(w_x_next);
    w_y_sat = sat(w_y_next);
  end

  // Request FSM, datapath registers and registered handshake outputs.
  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_x         <= '0;
      r_y         <= '0;
      r_dir       <= 1'b0;
      r_cnt       <= C_ZERO;
      r_out_x     <= '0;
      r_out_y     <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_x        <= w_x_in;
            r_y        <= w_y_in;
            r_dir      <= dir;
            r_cnt      <= steps;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
            if (steps == C_ZERO) begin
              r_state     <= S_DONE;
              r_out_x     <= x_pt;
              r_out_y     <= y_pt;
              r_out_valid <= 1'b1;
            end else begin
              r_state <= S_ROTATE;
            end
          end
        end
        S_ROTATE: begin
          r_x   <= w_x_sat;
          r_y   <= w_y_sat;
          r_cnt <= r_cnt - C_ONE;
          if (r_cnt == C_ONE) begin
            r_state     <= S_DONE;
            r_out_x     <= w_x_sat[WIDTH-1:0];
            r_out_y     <= w_y_sat[WIDTH-1:0];
            r_out_valid <= 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_cnt       <= C_ZERO;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
          r_in_ready  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign rotated_x = r_out_x;
  assign rotated_y = r_out_y;

endmodule

// File: tb/tb_derotate_z_seq.sv
// Self-checking bench for derotate_z_seq: vector table, hand-written corner sequences
// and randomized requests against an arithmetic reference model.
module tb_derotate_z_seq;

  logic       clk_100MHz;
  logic       reset_n;
  logic       in_valid;
  logic       in_ready;
  logic [9:0] x_pt;
  logic [9:0] y_pt;
  logic [3:0] steps;
  logic       dir;
  logic       out_valid;
  logic       out_ready;
  logic [9:0] rotated_x;
  logic [9:0] rotated_y;
  logic       busy;

  int n_chk;
  int n_err;

  derotate_z_seq #(.WIDTH(10), .STEP_W(4), .GUARD(2)) dut (
    .clk_100MHz(clk_100MHz),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x_pt      (x_pt),
    .y_pt      (y_pt),
    .steps     (steps),
    .dir       (dir),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .rotated_x (rotated_x),
    .rotated_y (rotated_y),
    .busy      (busy)
  );

  initial clk_100MHz = 1'b0;
  always #5 clk_100MHz = ~clk_100MHz;

  typedef struct {
    int x;
    int y;
    int n;
    bit d;
    int ex;
    int ey;
    int hold;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int floor_div(input int v, input int p);
    int r;
    r = ((v % p) + p) % p;
    return (v - r) / p;
  endfunction

  function automatic int clamp(input int v);
    if (v > 511) return 511;
    if (v < -512) return -512;
    return v;
  endfunction

  // Reference: repeated fixed-angle inverse steps with floor division and per-step clamp.
  task automatic model(input int x0, input int y0, input int n, input bit d,
                       output int ex, output int ey);
    int x, y, nx, ny, s;
    x = x0;
    y = y0;
    s = d ? -1 : 1;
    for (int k = 0; k < n; k++) begin
      nx = x - floor_div(x, 32) + s * (floor_div(y, 4) + floor_div(y, 128));
      ny = y - floor_div(y, 32) - s * (floor_div(x, 4) + floor_div(x, 128));
      x = clamp(nx);
      y = clamp(ny);
    end
    ex = x;
    ey = y;
  endtask

  task automatic run_req(input int x, input int y, input int n, input bit d,
                         input int ex, input int ey, input int hold, input string tag);
    int cyc;
    int ax, ay;
    cyc = 0;
    while (!in_ready && cyc < 50) begin
      @(posedge clk_100MHz); #1;
      cyc++;
    end
    check({tag, " in_ready"}, int'(in_ready), 1);
    x_pt = 10'(x); y_pt = 10'(y); steps = 4'(n); dir = d;
    in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk_100MHz); #1;
    in_valid = 1'b0; x_pt = 10'($urandom); y_pt = 10'($urandom);
    steps = 4'($urandom); dir = ~d;
    cyc = 0;
    while (!out_valid && cyc < 40) begin
      @(posedge clk_100MHz); #1;
      cyc++;
    end
    check({tag, " latency"}, cyc, n);
    ax = $signed(rotated_x);
    ay = $signed(rotated_y);
    check({tag, " x"}, ax, ex);
    check({tag, " y"}, ay, ey);
    check({tag, " busy"}, int'(busy), 1);
    check({tag, " in_ready_done"}, int'(in_ready), 0);
    for (int k = 0; k < hold; k++) begin
      in_valid = (k == 0);
      x_pt = 10'($urandom); y_pt = 10'($urandom); steps = 4'($urandom);
      @(posedge clk_100MHz); #1;
      ax = $signed(rotated_x);
      ay = $signed(rotated_y);
      check({tag, " hold valid"}, int'(out_valid), 1);
      check({tag, " hold x"}, ax, ex);
      check({tag, " hold y"}, ay, ey);
      check({tag, " hold in_ready"}, int'(in_ready), 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk_100MHz); #1;
    out_ready = 1'b0;
    ax = $signed(rotated_x);
    check({tag, " idle valid"}, int'(out_valid), 0);
    check({tag, " idle in_ready"}, int'(in_ready), 1);
    check({tag, " idle x held"}, ax, ex);
    @(posedge clk_100MHz); #1;
    check({tag, " not queued"}, int'(busy), 0);
  endtask

  vec_t vecs[7];

  initial begin
    int ex, ey, rx, ry, rn, hold_cnt;
    bit rd;
    n_chk = 0;
    n_err = 0;
    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    x_pt = 10'd0; y_pt = 10'd0; steps = 4'd0; dir = 1'b0;

    vecs[0] = '{x: 100,  y: 0,   n: 1, d: 1'b0, ex: 97,   ey: -25, hold: 0};
    vecs[1] = '{x: 100,  y: 0,   n: 2, d: 1'b0, ex: 86,   ey: -48, hold: 1};
    vecs[2] = '{x: 100,  y: 0,   n: 1, d: 1'b1, ex: 97,   ey: 25,  hold: 0};
    vecs[3] = '{x: -45,  y: 77,  n: 0, d: 1'b0, ex: -45,  ey: 77,  hold: 0};
    vecs[4] = '{x: -512, y: 0,   n: 1, d: 1'b0, ex: -496, ey: 132, hold: 2};
    vecs[5] = '{x: 511,  y: 511, n: 1, d: 1'b1, ex: 366,  ey: 511, hold: 0};
    vecs[6] = '{x: 100,  y: 0,   n: 1, d: 1'b0, ex: 97,   ey: -25, hold: 10};

    repeat (3) @(posedge clk_100MHz);
    #1;
    check("reset in_ready", int'(in_ready), 1);
    check("reset out_valid", int'(out_valid), 0);
    check("reset busy", int'(busy), 0);
    check("reset x", int'(rotated_x), 0);
    check("reset y", int'(rotated_y), 0);
    reset_n = 1'b1;
    @(posedge clk_100MHz); #1;

    for (int i = 0; i < 7; i++) begin
      run_req(vecs[i].x, vecs[i].y, vecs[i].n, vecs[i].d,
              vecs[i].ex, vecs[i].ey, vecs[i].hold, $sformatf("vec%0d", i));
    end

    // Reset during a long rotation aborts the request.
    x_pt = 10'd300; y_pt = 10'd200; steps = 4'd15; dir = 1'b0;
    in_valid = 1'b1;
    @(posedge clk_100MHz); #1;
    in_valid = 1'b0;
    check("abort busy", int'(busy), 1);
    repeat (4) @(posedge clk_100MHz);
    #1;
    reset_n = 1'b0;
    #1;
    check("abort in_ready", int'(in_ready), 1);
    check("abort busy0", int'(busy), 0);
    check("abort x", int'(rotated_x), 0);
    check("abort y", int'(rotated_y), 0);
    @(posedge clk_100MHz); #1;
    reset_n = 1'b1;
    hold_cnt = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk_100MHz); #1;
      if (out_valid) hold_cnt++;
    end
    check("abort no out_valid", hold_cnt, 0);
    run_req(-45, 77, 0, 1'b1, -45, 77, 0, "after abort");

    for (int i = 0; i < 30; i++) begin
      rx = int'($urandom_range(0, 1023)) - 512;
      ry = int'($urandom_range(0, 1023)) - 512;
      rn = int'($urandom_range(0, 15));
      rd = 1'($urandom_range(0, 1));
      model(rx, ry, rn, rd, ex, ey);
      run_req(rx, ry, rn, rd, ex, ey, int'($urandom_range(0, 3)), $sformatf("rnd%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
